shift_sub_div: RTL and testbench
================================

# shift_sub_div

Sequential signed restoring divider: divides a WIDTH-bit two's-complement dividend by a WIDTH-bit two's-complement divisor and produces quotient and remainder, one quotient bit per clock. It is the inverse companion of the shift-and-add multiplier in the multipliers area and uses the same sign-magnitude approach: convert operands to magnitudes, iterate on magnitudes, re-apply signs. A start/busy/done handshake lets a datapath controller issue one division at a time.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 4)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while idle (busy = 0)
- dividend  input  WIDTH  signed dividend; sampled on the accepting edge
- divisor  input  WIDTH  signed divisor; sampled on the accepting edge
- busy  output  1  high while a division is in progress
- done  output  1  single-cycle pulse when results are valid
- quotient  output  WIDTH  signed quotient; held until next done
- remainder  output  WIDTH  signed remainder; held until next done
- sign  output  1  dividend[MSB] XOR divisor[MSB] of the accepted operation
- div_by_zero  output  1  divisor was zero; held with results

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start = 1 → latch |dividend|, |divisor|, both operand MSBs, and the zero-divisor flag. Clear the partial remainder and iteration counter. Go to CALC.
- Magnitudes use WIDTH-bit two's negation. |-2^(WIDTH-1)| = 2^(WIDTH-1), treated as unsigned.
- CALC, once per cycle for WIDTH cycles, MSB first:
  - Form a (WIDTH+1)-bit partial remainder P = {R, next dividend bit}.
  - If P ≥ |divisor|: R = P − |divisor| and quotient bit = 1.
  - Otherwise: R = P and quotient bit = 0.
  - The counter reaches WIDTH−1 → FIX.
- FIX (one cycle), register the outputs:
  - quotient = sign ? −Qmag : Qmag.
  - remainder = dividend MSB ? −Rmag : Rmag.
  - Net effect: truncation toward zero, remainder takes the dividend's sign.
  - Assert done, go to IDLE.
- Divide by zero: runs the full latency.
  - FIX forces quotient = all ones and remainder = the raw dividend.
  - Asserts div_by_zero = 1; sign is computed normally.
- Overflow (−2^(WIDTH-1) / −1): quotient wraps to 0x80000000 (WIDTH=32), remainder 0. No flag.
- start while busy is ignored. No queuing.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset (async, any state):
  - state = IDLE.
  - busy, done, sign, div_by_zero = 0.
  - quotient, remainder = 0.
  - An in-flight operation is discarded; no done is produced for it.
- Edge E0 accepts start. busy = 1 from after E0.
- Edges E1..E(WIDTH) perform the iterations.
- Edge E(WIDTH+1) (the FIX edge) loads the results, sets done = 1, and sets busy = 0.
- Latency: done is high in the cycle following E(WIDTH+1), i.e. WIDTH+1 cycles after acceptance (33 for WIDTH=32). Throughput: one division per WIDTH+2 cycles.
- done lasts exactly one cycle. quotient, remainder, sign and div_by_zero are stable from done until the next done or reset.
- A start asserted during the done cycle (state IDLE) is accepted on that edge. Outputs keep their old values until the new done.
- start held continuously: back-to-back operations, each accepted in the cycle after the previous done.
- If reset is released mid-cycle with start = 1, the first accepting edge is the first rising edge with rst_n high.

## Test plan
- 100 / 7 → quotient 14, remainder 2, sign 0, div_by_zero 0. done exactly 33 cycles after the accepting edge, one cycle wide, busy low in the done cycle.
- Sign matrix, all truncating toward zero:
  - −100 / 7 → 0xFFFFFFF2 / 0xFFFFFFFE.
  - 100 / −7 → 0xFFFFFFF2 / 2.
  - −100 / −7 → 14 / 0xFFFFFFFE.
- 0x12345678 / 0 → quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1, same 33-cycle latency. The next 6 / 3 → 2 / 0 with div_by_zero cleared.
- Extremes:
  - 0x80000000 / 0xFFFFFFFF → 0x80000000 / 0.
  - 0x80000000 / 1 → 0x80000000 / 0.
  - 5 / 9 → 0 / 5.
  - 0 / 3 → 0 / 0.
- start pulsed again 5 cycles after acceptance with different operands → ignored, original result delivered. start held high → consecutive results 100/7 then 50/5 = 10/0, done pulses 34 cycles apart.
- rst_n driven low at cycle 10 of a division → busy, done, quotient and remainder go to 0 immediately (asynchronously). After release, no done appears until a new start.

Source files
------------

// File: rtl/shift_sub_div.sv
// Sequential signed restoring divider: one quotient bit per clock on operand
// magnitudes, signs re-applied in a final fix-up cycle.
module shift_sub_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_sign,
  output logic             o_div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_raw;
  logic             r_msb_a;
  logic             r_msb_b;
  logic             r_dz;

  logic             w_accept;
  logic             w_iter;
  logic             w_fix;
  logic             w_last;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_p;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;

  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_abs_a = i_dividend[WIDTH-1] ? (WIDTH'(0) - i_dividend) : i_dividend;
  assign w_abs_b = i_divisor[WIDTH-1]  ? (WIDTH'(0) - i_divisor)  : i_divisor;

  // Restoring step: the difference is only used when P >= divisor, so it fits in WIDTH bits.
  assign w_p       = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge      = (w_p >= {1'b0, r_dvs});
  assign w_diff    = w_p[WIDTH-1:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_diff : w_p[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_CALC;
      S_CALC:  if (w_last)  w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_iter   = 1'b0;
    w_fix    = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = i_start;
      S_CALC:  w_iter   = 1'b1;
      S_FIX:   w_fix    = 1'b1;
      default: ;
    endcase
  end

  // Iteration datapath on magnitudes; quotient bits shift in from the right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_raw   <= '0;
      r_msb_a <= 1'b0;
      r_msb_b <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_dvd   <= w_abs_a;
      r_dvs   <= w_abs_b;
      r_rem   <= '0;
      r_quo   <= '0;
      r_raw   <= i_dividend;
      r_msb_a <= i_dividend[WIDTH-1];
      r_msb_b <= i_divisor[WIDTH-1];
      r_dz    <= (i_divisor == '0);
    end else if (w_iter) begin
      r_cnt <= r_cnt + CW'(1);
      r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
      r_rem <= w_rem_nxt;
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_sign        <= 1'b0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done <= w_fix;
      if (w_accept)   o_busy <= 1'b1;
      else if (w_fix) o_busy <= 1'b0;
      if (w_fix) begin
        o_sign        <= r_msb_a ^ r_msb_b;
        o_div_by_zero <= r_dz;
        if (r_dz) begin
          o_quotient  <= '1;
          o_remainder <= r_raw;
        end else begin
          o_quotient  <= (r_msb_a ^ r_msb_b) ? (WIDTH'(0) - r_quo) : r_quo;
          o_remainder <= r_msb_a ? (WIDTH'(0) - r_rem) : r_rem;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_sub_div.sv
// Bench for shift_sub_div: directed and random divisions compared against
// a plain-arithmetic reference (truncating division, remainder follows dividend).
module tb_shift_sub_div;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;
  logic         o_sign;
  logic         o_div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  shift_sub_div #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_sign       (o_sign),
    .o_div_by_zero(o_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic s, output logic z);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    s  = a[W-1] ^ b[W-1];
    z  = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  // Called at posedge+1 with the divider idle; accepts one op and checks it.
  // pulse_at > 0 injects a second start (other operands) that must be ignored.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int pulse_at);
    logic [W-1:0] eq, er;
    logic es, ez;
    int cyc;
    model(a, b, eq, er, es, ez);
    i_start = 1'b1; i_dividend = a; i_divisor = b;
    @(posedge clk); #1;
    i_start = 1'b0; i_dividend = $urandom; i_divisor = $urandom;
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_errors++; $display("FAIL busy_after_accept got %b exp 1", o_busy);
    end
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 40) begin
      if (pulse_at > 0 && cyc == pulse_at) i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      cyc++;
    end
    n_checks++;
    if (cyc !== 33) begin
      n_errors++; $display("FAIL latency %h/%h got %0d exp 33", a, b, cyc);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_errors++; $display("FAIL busy_in_done got %b exp 0", o_busy);
    end
    n_checks++;
    if (o_quotient !== eq) begin
      n_errors++; $display("FAIL quotient %h/%h got %h exp %h", a, b, o_quotient, eq);
    end
    n_checks++;
    if (o_remainder !== er) begin
      n_errors++; $display("FAIL remainder %h/%h got %h exp %h", a, b, o_remainder, er);
    end
    n_checks++;
    if (o_sign !== es || o_div_by_zero !== ez) begin
      n_errors++;
      $display("FAIL flags %h/%h got sign %b dz %b exp sign %b dz %b", a, b, o_sign, o_div_by_zero, es, ez);
    end
    @(posedge clk); #1;
    n_checks++;
    if (o_done !== 1'b0 || o_quotient !== eq || o_remainder !== er) begin
      n_errors++;
      $display("FAIL done_width/hold got done %b q %h r %h exp done 0 q %h r %h", o_done, o_quotient, o_remainder, eq, er);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_dividend = '0; i_divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o_busy, o_done, o_sign, o_div_by_zero} !== 4'b0 || o_quotient !== '0 || o_remainder !== '0) begin
      n_errors++;
      $display("FAIL reset_state got busy %b done %b sign %b dz %b q %h r %h exp all 0",
               o_busy, o_done, o_sign, o_div_by_zero, o_quotient, o_remainder);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_div(32'd100, 32'd7, 0);
    n_checks++;
    if (o_quotient !== 32'd14 || o_remainder !== 32'd2) begin
      n_errors++; $display("FAIL const_100_7 got %h/%h exp 0000000e/00000002", o_quotient, o_remainder);
    end
    do_div(-32'sd100, 32'd7, 0);
    n_checks++;
    if (o_quotient !== 32'hFFFF_FFF2 || o_remainder !== 32'hFFFF_FFFE) begin
      n_errors++; $display("FAIL const_m100_7 got %h/%h exp fffffff2/fffffffe", o_quotient, o_remainder);
    end
    do_div(32'd100, -32'sd7, 0);
    do_div(-32'sd100, -32'sd7, 0);
    do_div(32'h1234_5678, 32'd0, 0);
    n_checks++;
    if (o_quotient !== 32'hFFFF_FFFF || o_remainder !== 32'h1234_5678 || o_div_by_zero !== 1'b1) begin
      n_errors++; $display("FAIL const_div0 got %h/%h dz %b exp ffffffff/12345678 dz 1",
                           o_quotient, o_remainder, o_div_by_zero);
    end
    do_div(32'd6, 32'd3, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
    n_checks++;
    if (o_quotient !== 32'h8000_0000 || o_remainder !== 32'd0) begin
      n_errors++; $display("FAIL const_overflow got %h/%h exp 80000000/00000000", o_quotient, o_remainder);
    end
    do_div(32'h8000_0000, 32'd1, 0);
    do_div(32'd5, 32'd9, 0);
    do_div(32'd0, 32'd3, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = W'($urandom_range(1, 15));
        2:       b = W'(0) - W'($urandom_range(1, 15));
        3:       b = (($urandom_range(0, 1)) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      do_div(a, b, 0);
    end
  endtask

  task automatic test_ignore_start();
    do_div(32'd100, 32'd7, 5);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int gap;
    i_start = 1'b1; i_dividend = 32'd100; i_divisor = 32'd7;
    @(posedge clk); #1;
    i_dividend = 32'd50; i_divisor = 32'd5;
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    n_checks++;
    if (cyc !== 33 || o_quotient !== 32'd14 || o_remainder !== 32'd2) begin
      n_errors++; $display("FAIL b2b_first got cyc %0d q %h r %h exp 33 0000000e 00000002", cyc, o_quotient, o_remainder);
    end
    @(posedge clk); #1;
    i_start = 1'b0;
    gap = 1;
    while (o_done !== 1'b1 && gap < 45) begin
      @(posedge clk); #1; gap++;
    end
    n_checks++;
    if (gap !== 34 || o_quotient !== 32'd10 || o_remainder !== 32'd0) begin
      n_errors++; $display("FAIL b2b_second got gap %0d q %h r %h exp 34 0000000a 00000000", gap, o_quotient, o_remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int spurious;
    i_start = 1'b1; i_dividend = 32'd77; i_divisor = 32'd5;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_quotient !== '0 || o_remainder !== '0) begin
      n_errors++; $display("FAIL async_reset got busy %b done %b q %h r %h exp 0 0 0 0",
                           o_busy, o_done, o_quotient, o_remainder);
    end
    @(negedge clk); rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (o_done !== 1'b0 || o_busy !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious !== 0) begin
      n_errors++; $display("FAIL no_done_after_reset got %0d active cycles exp 0", spurious);
    end
    do_div(32'd6, 32'd3, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
